inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage feeding the next-PC/delay-slot tagging stage. Holds the fetch PC and
//  issues word reads to instruction memory over a valid/ready channel. Returned words are queued
//  in a small FIFO and presented as {instr, pc, inst_valid}; nextu_ready pops the queue.
//  A redirect (taken branch / exception) reloads the PC from next_pc and squashes stale fetches.
// PARAMETERS
//  DATA_WIDTH  32            datapath / address width
//  RESET_PC    32'hbfc00000  fetch address after reset
//  FIFO_DEPTH  4             instruction queue entries; also the credit limit (power of 2, >=2)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   asynchronous, active-low reset
//  redirect        in   1   branch_ready from next-PC stage: reload PC, flush
//  next_pc         in   32  redirect target, sampled when redirect=1
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address of request
//  imem_resp_valid in   1   read data valid (in request order)
//  imem_resp_data  in   32  instruction word
//  imem_resp_ready out  1   tied 1; responses never back-pressured
//  inst_valid      out  1   FIFO head valid
//  instr           out  32  head instruction (0 when empty or adel)
//  pc              out  32  head PC (0 when empty)
//  inst_adel       out  1   head entry is a misaligned-fetch fault
//  nextu_ready     in   1   consumer pops head when inst_valid & nextu_ready
// BEHAVIOUR
//  Reset (rst=0, async): fetch_pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, FIFO empty,
//   inst_valid=0, instr=0, pc=0, inst_adel=0, outstanding=0, drop=0.
//  Credit: new request may start only if outstanding+fifo_count < FIFO_DEPTH; a FIFO push can
//   therefore never find it full. Push while full is an assertion failure.
//  Request: when idle and credit is available and fetch_pc[1:0]==0, register imem_req_valid=1 and
//   imem_req_addr=fetch_pc. Valid and address are held stable until imem_req_ready (no withdrawal).
//   On handshake: outstanding+1, fetch_pc+=4 (wraps mod 2^32).
//  Response: each imem_resp_valid decrements outstanding. If drop>0: discard and drop-1;
//   otherwise push {data, addr, adel=0}. Response PCs come from an internal in-order PC queue.
//  Misaligned: if fetch_pc[1:0]!=0, no memory request. Once outstanding==0, push
//   {instr=0, pc=fetch_pc, adel=1} once. Fetch then stalls until redirect.
//  Latency: request accepted cycle N, response cycle M>N; inst_valid rises at M+1 (no bypass).
//   Back-to-back responses sustain 1 instr/cycle.
//  Redirect (cycle R):
//   - fetch_pc<=next_pc.
//   - FIFO cleared; a pop in cycle R still completes first.
//   - drop<=outstanding (+1 if a request handshakes in R, -1 if a non-dropped response arrives
//     in R; that response is discarded).
//   - A pending unaccepted request stays valid. It is counted into drop when it is accepted.
//   - Fetch from the new PC is issued at R+1 at earliest.
//   - Delay-slot instructions have been consumed before redirect; the flush discards all entries.
//  Simultaneous push+pop: count unchanged. Redirect+push in the same cycle: redirect wins.
//  Counters: outstanding/drop/count are clog2(FIFO_DEPTH)+1 bits and never underflow.
//   A response with outstanding==0 is an assertion failure.
// TESTING
//  1 Reset release, memory ready=1, 1-cycle response: addrs bfc00000,04,08... observed;
//    inst_valid first at cycle 3; pc sequence matches addrs.
//  2 nextu_ready=0 for 10 cycles: exactly 4 requests issued, then req_valid=0. Pop one, and
//    exactly one new request follows.
//  3 Redirect to 80000180 with 2 in flight + 1 pending unaccepted: those 3 responses are dropped.
//    The first inst_valid afterwards shows pc=80000180.
//  4 Redirect to 80000102: no memory request issued; head becomes inst_adel=1, instr=0,
//    pc=80000102, and stays until popped; no further fetch until the next redirect.
//  5 Redirect, response and pop in the same cycle: the popped head is delivered. The response is
//    dropped, and no stale PC ever reaches the output.
//  6 Assert rst mid-burst with responses pending: outputs return to reset values in the same
//    cycle; after release, fetch restarts at bfc00000.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, credit-limited request channel to imem, in-order response
// PC tracking, and an instruction queue toward the next-PC stage. Redirect flushes and squashes.
module inst_fetch #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] next_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  imem_resp_ready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  inst_adel,
  input  logic                  nextu_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic                  adel;
  } ent_t;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d;
  logic                  req_valid_q, req_valid_d, stale_q, stale_d, adel_done_q, adel_done_d;
  logic [CW-1:0]         outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0]         rd_q, rd_d, wr_q, wr_d, pcq_rd_q, pcq_wr_q;
  ent_t                  fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pcq_q  [FIFO_DEPTH];

  logic hs, resp_dec, resp_keep, adel_push, push, pop, req_free, credit, issue;
  ent_t push_ent, head;

  assign hs        = req_valid_q & imem_req_ready;
  assign resp_dec  = imem_resp_valid & (outst_q != '0);
  assign resp_keep = resp_dec & (drop_q == '0);
  // A misaligned PC never goes to memory; its fault entry waits for older fetches to drain.
  assign adel_push = (fetch_pc_q[1:0] != 2'b00) & ~req_valid_q & (outst_q == '0) &
                     ~adel_done_q & (cnt_q < CW'(FIFO_DEPTH));
  assign push      = ~redirect & (resp_keep | adel_push);
  assign inst_valid = (cnt_q != '0);
  assign pop       = inst_valid & nextu_ready;
  assign head      = fifo_q[rd_q];

  always_comb begin
    push_ent = '0;
    if (adel_push) begin
      push_ent.pc   = fetch_pc_q;
      push_ent.adel = 1'b1;
    end else begin
      push_ent.instr = imem_resp_data;
      push_ent.pc    = pcq_q[pcq_rd_q];
    end
  end

  always_comb begin
    outst_d     = outst_q + CW'(hs) - CW'(resp_dec);
    fetch_pc_d  = fetch_pc_q;
    stale_d     = stale_q;
    adel_done_d = adel_done_q | adel_push;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    rd_d        = rd_q + AW'(pop);
    wr_d        = wr_q + AW'(push);
    drop_d      = drop_q - CW'(resp_dec & (drop_q != '0)) + CW'(hs & stale_q);
    if (hs) stale_d = 1'b0;
    if (hs & ~stale_q) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc_d  = next_pc;
      drop_d      = outst_d;
      stale_d     = req_valid_q & ~imem_req_ready;
      adel_done_d = 1'b0;
      cnt_d       = '0;
      rd_d        = '0;
      wr_d        = '0;
    end
    req_free    = ~req_valid_q | hs;
    credit      = ({1'b0, outst_d} + {1'b0, cnt_d}) < (CW+1)'(FIFO_DEPTH);
    issue       = req_free & ~redirect & (fetch_pc_d[1:0] == 2'b00) & credit;
    req_valid_d = issue | (req_valid_q & ~hs);
    req_addr_d  = issue ? fetch_pc_d : req_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      stale_q     <= 1'b0;
      adel_done_q <= 1'b0;
      outst_q     <= '0;
      drop_q      <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      pcq_rd_q    <= '0;
      pcq_wr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      stale_q     <= stale_d;
      adel_done_q <= adel_done_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      pcq_rd_q    <= pcq_rd_q + AW'(resp_dec);
      pcq_wr_q    <= pcq_wr_q + AW'(hs);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= push_ent;
    if (hs)   pcq_q[pcq_wr_q] <= req_addr_q;
  end

  assign imem_req_valid  = req_valid_q;
  assign imem_req_addr   = req_addr_q;
  assign imem_resp_ready = 1'b1;
  assign instr           = inst_valid ? head.instr : '0;
  assign pc              = inst_valid ? head.pc    : '0;
  assign inst_adel       = inst_valid & head.adel;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && cnt_q == CW'(FIFO_DEPTH)));
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    !(imem_resp_valid && outst_q == '0));
endmodule
